// File: rtl/dvr_key_arb_ctr_if.sv
// Request side (per-channel key/sync/count) and encryptor-facing block stream
// of the round-robin key/sync burst source.
interface dvr_key_arb_ctr_if #(
  parameter int NUM_CHANNELS        = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int CNT_WIDTH           = 8
);
  localparam int W    = 8 * DATA_WIDTH_IN_BYTES;
  localparam int CH_W = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS*W-1:0]         in_key;
  logic [NUM_CHANNELS*W-1:0]         in_sync;
  logic [NUM_CHANNELS*CNT_WIDTH-1:0] in_blocks;
  logic [NUM_CHANNELS-1:0]           in_valid;
  logic [NUM_CHANNELS-1:0]           in_rdy;
  logic [W-1:0]                      out_key;
  logic [W-1:0]                      out_sync;
  logic [CH_W-1:0]                   out_channel;
  logic                              out_last;
  logic                              out_valid;
  logic                              out_rdy;

  modport slave (
    input  in_key, in_sync, in_blocks, in_valid, out_rdy,
    output in_rdy, out_key, out_sync, out_channel, out_last, out_valid
  );

  modport master (
    output in_key, in_sync, in_blocks, in_valid, out_rdy,
    input  in_rdy, out_key, out_sync, out_channel, out_last, out_valid
  );
endinterface

// File: rtl/dvr_key_arb_ctr.sv
// Round-robin arbiter over key/sync requesters that expands each grant into a
// counter-mode burst: same key, sync stepped once per accepted block.
module dvr_key_arb_ctr #(
  parameter int NUM_CHANNELS        = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int CNT_WIDTH           = 8,
  parameter int SYNC_INC_MODE       = 0
) (
  input logic              clk,
  input logic              rst,
  dvr_key_arb_ctr_if.slave bus
);
  localparam int W    = 8 * DATA_WIDTH_IN_BYTES;
  localparam int CH_W = $clog2(NUM_CHANNELS);

  generate
    if (NUM_CHANNELS < 2) begin : g_bad_nc
      $error("dvr_key_arb_ctr: NUM_CHANNELS must be at least 2");
    end
    if (SYNC_INC_MODE != 0 && SYNC_INC_MODE != 1) begin : g_bad_mode
      $error("dvr_key_arb_ctr: SYNC_INC_MODE must be 0 or 1");
    end
    if (SYNC_INC_MODE == 1 && W < 32) begin : g_bad_w
      $error("dvr_key_arb_ctr: SYNC_INC_MODE 1 needs at least 4-byte sync");
    end
  endgenerate

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    remaining_q;
  logic [CH_W-1:0]         last_grant_q;
  logic [W-1:0]            key_p1;
  logic [W-1:0]            sync_p1;
  logic [CH_W-1:0]         chan_p1;
  logic                    vld_p1;
  logic                    last_p1;
  logic                    xfer;
  logic                    gnt_found;
  logic [CH_W-1:0]         gnt_idx;
  logic [CNT_WIDTH-1:0]    gnt_blocks;
  logic [NUM_CHANNELS-1:0] rdy;

  // Mode 1 confines the carry to the low 32 bits so the upper sync field is a fixed nonce.
  function automatic logic [W-1:0] sync_inc(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = s + W'(1);
    if (SYNC_INC_MODE == 1) begin
      r        = s;
      r[31:0]  = s[31:0] + 32'd1;
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] blocks_floor(input logic [CNT_WIDTH-1:0] b);
    return (b == '0) ? CNT_WIDTH'(1) : b;
  endfunction

  // Search starts just past the previous winner, so every channel gets a turn.
  always_comb begin
    int c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      c = (int'(last_grant_q) + k) % NUM_CHANNELS;
      if (!gnt_found && bus.in_valid[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
      end
    end
  end

  assign gnt_blocks = bus.in_blocks[gnt_idx*CNT_WIDTH +: CNT_WIDTH];
  assign vld_p1     = (state_q == BURST);
  assign last_p1    = vld_p1 && (remaining_q == CNT_WIDTH'(1));
  assign xfer       = vld_p1 && bus.out_rdy;

  always_comb begin
    state_d = state_q;
    rdy     = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          rdy[gnt_idx] = 1'b1;
          state_d      = BURST;
        end
      end
      BURST: begin
        if (xfer && last_p1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant (p0) -> output block registers (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      last_grant_q <= CH_W'(NUM_CHANNELS - 1);
      key_p1       <= '0;
      sync_p1      <= '0;
      chan_p1      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (gnt_found) begin
          key_p1       <= bus.in_key[gnt_idx*W +: W];
          sync_p1      <= bus.in_sync[gnt_idx*W +: W];
          chan_p1      <= gnt_idx;
          remaining_q  <= blocks_floor(gnt_blocks);
          last_grant_q <= gnt_idx;
        end
      end else if (xfer && !last_p1) begin
        remaining_q <= remaining_q - CNT_WIDTH'(1);
        sync_p1     <= sync_inc(sync_p1);
      end
    end
  end

  assign bus.in_rdy      = rdy;
  assign bus.out_valid   = vld_p1;
  assign bus.out_last    = last_p1;
  assign bus.out_key     = key_p1;
  assign bus.out_sync    = sync_p1;
  assign bus.out_channel = chan_p1;
endmodule

// File: tb/tb_dvr_key_arb_ctr.sv
// Randomised and directed bench for dvr_key_arb_ctr: two instances (sync modes 0 and 1)
// share stimulus and are compared every cycle against a burst-list reference model.
module tb_dvr_key_arb_ctr;
  localparam int NC   = 4;
  localparam int DB   = 16;
  localparam int CW   = 8;
  localparam int W    = 8 * DB;
  localparam int CH_W = $clog2(NC);
  localparam int VW   = 2 + CH_W + 2 * W + NC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC*W-1:0]  v_key    = '0;
  logic [NC*W-1:0]  v_sync   = '0;
  logic [NC*CW-1:0] v_blocks = '0;
  logic [NC-1:0]    v_valid  = '0;
  logic             ordy     = 1'b0;

  dvr_key_arb_ctr_if #(.NUM_CHANNELS(NC), .DATA_WIDTH_IN_BYTES(DB), .CNT_WIDTH(CW)) bus0 ();
  dvr_key_arb_ctr_if #(.NUM_CHANNELS(NC), .DATA_WIDTH_IN_BYTES(DB), .CNT_WIDTH(CW)) bus1 ();

  assign bus0.in_key    = v_key;
  assign bus0.in_sync   = v_sync;
  assign bus0.in_blocks = v_blocks;
  assign bus0.in_valid  = v_valid;
  assign bus0.out_rdy   = ordy;
  assign bus1.in_key    = v_key;
  assign bus1.in_sync   = v_sync;
  assign bus1.in_blocks = v_blocks;
  assign bus1.in_valid  = v_valid;
  assign bus1.out_rdy   = ordy;

  dvr_key_arb_ctr #(.NUM_CHANNELS(NC), .DATA_WIDTH_IN_BYTES(DB), .CNT_WIDTH(CW), .SYNC_INC_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  dvr_key_arb_ctr #(.NUM_CHANNELS(NC), .DATA_WIDTH_IN_BYTES(DB), .CNT_WIDTH(CW), .SYNC_INC_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: a grant precomputes the whole burst as a list of blocks.
  typedef struct packed {
    logic [W-1:0]    key;
    logic [W-1:0]    s0;
    logic [W-1:0]    s1;
    logic [CH_W-1:0] chan;
    logic            last;
  } blk_t;

  blk_t q[$];
  blk_t cur     = '0;
  bit   busy    = 1'b0;
  int   rr_last = NC - 1;

  function automatic int pick();
    for (int k = 1; k <= NC; k++) begin
      if (v_valid[(rr_last + k) % NC]) return (rr_last + k) % NC;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g, n;
    blk_t b;
    logic [W-1:0] s0, s1;
    if (rst) begin
      busy = 1'b0; q.delete(); cur = '0; rr_last = NC - 1;
    end else if (busy) begin
      if (ordy) begin
        void'(q.pop_front());
        if (q.size() == 0) busy = 1'b0;
        else cur = q[0];
      end
    end else begin
      g = pick();
      if (g >= 0) begin
        n = int'(v_blocks[g*CW +: CW]);
        if (n == 0) n = 1;
        s0 = v_sync[g*W +: W];
        s1 = s0;
        q.delete();
        for (int j = 0; j < n; j++) begin
          b.key = v_key[g*W +: W]; b.s0 = s0; b.s1 = s1;
          b.chan = CH_W'(g); b.last = (j == n - 1);
          q.push_back(b);
          s0 = s0 + 1'b1;
          s1[31:0] = s1[31:0] + 32'd1;
        end
        busy = 1'b1; rr_last = g; cur = q[0];
      end
    end
  end

  function automatic logic [VW-1:0] exp_now(input int m);
    int g;
    logic [NC-1:0] r;
    r = '0;
    g = pick();
    if (!busy && g >= 0) r[g] = 1'b1;
    return {busy, busy & cur.last, cur.chan, cur.key, (m == 0) ? cur.s0 : cur.s1, r};
  endfunction

  function automatic logic [VW-1:0] obs_now(input int m);
    if (m == 0)
      return {bus0.out_valid, bus0.out_last, bus0.out_channel, bus0.out_key, bus0.out_sync, bus0.in_rdy};
    return {bus1.out_valid, bus1.out_last, bus1.out_channel, bus1.out_key, bus1.out_sync, bus1.in_rdy};
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic vld, input logic [W-1:0] k,
                        input logic [W-1:0] s, input int b);
    v_key[ch*W +: W]     = k;
    v_sync[ch*W +: W]    = s;
    v_blocks[ch*CW +: CW] = CW'(b);
    v_valid[ch]          = vld;
  endtask

  logic [W-1:0]    cap_s0[$];
  logic [W-1:0]    cap_s1[$];
  logic            cap_last[$];
  logic [CH_W-1:0] cap_chan[$];

  // Records every accepted block; the one-shot request is withdrawn after its grant cycle.
  task automatic capture(input int n);
    cap_s0.delete(); cap_s1.delete(); cap_last.delete(); cap_chan.delete();
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (bus0.out_valid && ordy) begin
        cap_s0.push_back(bus0.out_sync);
        cap_s1.push_back(bus1.out_sync);
        cap_last.push_back(bus0.out_last);
        cap_chan.push_back(bus0.out_channel);
      end
      cyc();
      if (t == 0) v_valid = '0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    v_valid = '0;
    ordy    = 1'b1;
    while ((bus0.out_valid || bus1.out_valid) && n < 300) begin
      cyc();
      n++;
    end
    total++;
    if (bus0.out_valid || bus1.out_valid) begin
      bad++;
      $display("FAIL drain_timeout out_valid=%b/%b required 0/0", bus0.out_valid, bus1.out_valid);
    end
    cyc();
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs_now(m) !== {VW{1'b0}}) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%h required=0", m, obs_now(m));
      end
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int nrdy;
    logic [W-1:0] k1;
    k1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    nrdy = 0;
    ordy = 1'b1;
    cap_s0.delete(); cap_last.delete(); cap_chan.delete();
    set_ch(1, 1'b1, k1, 128'h5, 3);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs_now(m) !== exp_now(m)) begin
          bad++;
          $display("FAIL single_cycle t=%0d dut%0d got=%h required=%h", t, m, obs_now(m), exp_now(m));
        end
      end
      if (t == 0) begin
        total++;
        if (bus0.in_rdy !== 4'b0010 || bus0.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL single_grant in_rdy=%b out_valid=%b required 0010/0", bus0.in_rdy, bus0.out_valid);
        end
      end
      if (bus0.in_rdy != '0) nrdy++;
      if (bus0.out_valid) begin
        cap_s0.push_back(bus0.out_sync);
        cap_last.push_back(bus0.out_last);
        cap_chan.push_back(bus0.out_channel);
        total++;
        if (bus0.out_key !== k1) begin
          bad++;
          $display("FAIL single_key got=%h required=%h", bus0.out_key, k1);
        end
      end
      cyc();
      if (t == 0) v_valid = '0;
    end
    total++;
    if (nrdy != 1) begin
      bad++;
      $display("FAIL single_rdy_cycles got=%0d required=1", nrdy);
    end
    total++;
    if (cap_s0.size() != 3 || cap_s0[0] !== 128'h5 || cap_s0[1] !== 128'h6 || cap_s0[2] !== 128'h7) begin
      bad++;
      $display("FAIL single_syncs count=%0d required 3 blocks with sync 5,6,7", cap_s0.size());
    end
    total++;
    if (cap_last.size() != 3 || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b0 || cap_last[2] !== 1'b1 ||
        cap_chan[0] !== 2'd1 || cap_chan[2] !== 2'd1) begin
      bad++;
      $display("FAIL single_last_chan count=%0d required last only on block 3, channel 1", cap_last.size());
    end
  endtask

  task automatic test_round_robin();
    int gch[$];
    int gcyc[$];
    int want[5];
    drain();
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c < NC; c++) set_ch(c, 1'b1, rand_w(), rand_w(), 1);
    ordy = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs_now(m) !== exp_now(m)) begin
          bad++;
          $display("FAIL rr_cycle t=%0d dut%0d got=%h required=%h", t, m, obs_now(m), exp_now(m));
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (bus0.in_rdy[c]) begin
          gch.push_back(c);
          gcyc.push_back(t);
        end
      end
      cyc();
    end
    v_valid = '0;
    want = '{0, 1, 2, 3, 0};
    total++;
    if (gch.size() != 5) begin
      bad++;
      $display("FAIL rr_grant_count got=%0d required=5", gch.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (gch[i] != want[i] || gcyc[i] != 2 * i) begin
          bad++;
          $display("FAIL rr_order idx=%0d got ch%0d@%0d required ch%0d@%0d", i, gch[i], gcyc[i], want[i], 2 * i);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    int stalls, acc;
    logic [W-1:0] sk, ss;
    logic [W-1:0] acc_s[$];
    stalls = 0; acc = 0; sk = '0; ss = '0;
    drain();
    ordy = 1'b0;
    set_ch(2, 1'b1, rand_w(), rand_w(), 2);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs_now(m) !== exp_now(m)) begin
          bad++;
          $display("FAIL bp_cycle t=%0d dut%0d got=%h required=%h", t, m, obs_now(m), exp_now(m));
        end
      end
      if (bus0.out_valid) begin
        total++;
        if (bus0.in_rdy !== '0) begin
          bad++;
          $display("FAIL bp_in_rdy got=%b required=0000", bus0.in_rdy);
        end
        if (stalls == 0 && acc == 0 && !ordy) begin
          sk = bus0.out_key; ss = bus0.out_sync;
        end
        if (!ordy) begin
          stalls++;
          total++;
          if (bus0.out_key !== sk || bus0.out_sync !== ss || bus0.out_last !== 1'b0 || bus0.out_channel !== 2'd2) begin
            bad++;
            $display("FAIL bp_stable got sync=%h last=%b required sync=%h last=0", bus0.out_sync, bus0.out_last, ss);
          end
        end else begin
          acc++;
          acc_s.push_back(bus0.out_sync);
        end
      end
      cyc();
      if (t == 0) v_valid = '0;
      if (stalls == 5) ordy = 1'b1;
    end
    total++;
    if (acc != 2 || acc_s[0] !== ss || acc_s[1] !== ss + 1'b1) begin
      bad++;
      $display("FAIL bp_accepts got=%0d required 2 blocks with sync %h, +1", acc, ss);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] ones, hi_keep, s2;
    ones    = '1;
    hi_keep = ones & ~{{(W-32){1'b0}}, 32'hFFFF_FFFF};
    drain();
    ordy = 1'b1;
    set_ch(0, 1'b1, rand_w(), ones, 2);
    capture(5);
    total++;
    if (cap_s0.size() != 2 || cap_s0[0] !== ones || cap_s0[1] !== '0) begin
      bad++;
      $display("FAIL wrap_mode0 count=%0d second=%h required=0", cap_s0.size(), (cap_s0.size() > 1) ? cap_s0[1] : ones);
    end
    total++;
    if (cap_s1.size() != 2 || cap_s1[1] !== hi_keep) begin
      bad++;
      $display("FAIL wrap_mode1_ones count=%0d second=%h required=%h", cap_s1.size(), (cap_s1.size() > 1) ? cap_s1[1] : ones, hi_keep);
    end
    drain();
    s2 = {{(W-33){1'b0}}, 33'h1_FFFF_FFFF};
    set_ch(0, 1'b1, rand_w(), s2, 2);
    capture(5);
    total++;
    if (cap_s1.size() != 2 || cap_s1[1] !== {{(W-33){1'b0}}, 33'h1_0000_0000}) begin
      bad++;
      $display("FAIL wrap_mode1 count=%0d second=%h required=100000000", cap_s1.size(), (cap_s1.size() > 1) ? cap_s1[1] : s2);
    end
    total++;
    if (cap_s0.size() != 2 || cap_s0[1] !== {{(W-34){1'b0}}, 34'h2_0000_0000}) begin
      bad++;
      $display("FAIL wrap_mode0_carry count=%0d second=%h required=200000000", cap_s0.size(), (cap_s0.size() > 1) ? cap_s0[1] : s2);
    end
  endtask

  task automatic test_zero_count();
    logic [W-1:0] s;
    s = rand_w();
    drain();
    ordy = 1'b1;
    set_ch(3, 1'b1, rand_w(), s, 0);
    capture(5);
    total++;
    if (cap_s0.size() != 1 || cap_last[0] !== 1'b1 || cap_chan[0] !== 2'd3 || cap_s0[0] !== s) begin
      bad++;
      $display("FAIL zero_count blocks=%0d required 1 block, last=1, channel 3", cap_s0.size());
    end
  endtask

  task automatic test_mid_reset();
    int acc, t;
    acc = 0; t = 0;
    drain();
    ordy = 1'b1;
    set_ch(2, 1'b1, rand_w(), rand_w(), 8);
    @(negedge clk);
    cyc();
    v_valid = '0;
    while (acc < 2 && t < 20) begin
      @(negedge clk);
      if (bus0.out_valid && ordy) acc++;
      cyc();
      t++;
    end
    total++;
    if (acc != 2) begin
      bad++;
      $display("FAIL midrst_blocks got=%0d required=2", acc);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_abort i=%0d out_valid=%b/%b required 0/0", i, bus0.out_valid, bus1.out_valid);
      end
      cyc();
    end
    for (int c = 0; c < NC; c++) set_ch(c, 1'b1, rand_w(), rand_w(), 1);
    @(negedge clk);
    total++;
    if (bus0.in_rdy !== 4'b0001 || bus1.in_rdy !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_priority in_rdy=%b/%b required 0001", bus0.in_rdy, bus1.in_rdy);
    end
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs_now(m) !== exp_now(m)) begin
        bad++;
        $display("FAIL midrst_state dut%0d got=%h required=%h", m, obs_now(m), exp_now(m));
      end
    end
    cyc();
    v_valid = '0;
  endtask

  task automatic test_random();
    drain();
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < NC; c++) begin
        set_ch(c, 1'($urandom_range(0, 1)), rand_w(), ($urandom_range(0, 7) == 0) ? '1 : rand_w(),
               int'($urandom_range(0, 3)));
      end
      ordy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs_now(m) !== exp_now(m)) begin
          bad++;
          $display("FAIL random t=%0d dut%0d got=%h required=%h", t, m, obs_now(m), exp_now(m));
        end
      end
      cyc();
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_wrap();
    test_zero_count();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
